// File: rtl/wave_rom_seq.sv
// Phase-accumulator waveform sequencer: walks a synchronous ROM at a divided sample rate and
// registers each sample for a DAC. Define WAVE_ROM_SEQ_AMP_EN to add an 8-bit amplitude scaling stage.
module wave_rom_seq #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_we,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ADDR_W-1:0] cfg_poff,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout,
`ifdef WAVE_ROM_SEQ_AMP_EN
  input  logic [7:0]        amp,
`endif
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              wrap,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]  acc_q;
  logic [DIV_W-1:0]  cnt_q;
  logic              first_q;
  logic [ACC_W-1:0]  ftw_q;
  logic [ADDR_W-1:0] poff_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_act_q;
  logic [ADDR_W-1:0] rom_ad_q;
  logic              rom_ce_q;
  logic              rd_q;
  logic              wrap_q;
  logic [DATA_W-1:0] dac_data_q;
  logic              dac_valid_q;
`ifdef WAVE_ROM_SEQ_AMP_EN
  logic              amp_v_q;
  logic [DATA_W-1:0] prod_q;
  logic [DATA_W+7:0] prod;
`endif

  logic              active;
  logic              go;
  logic              tick;
  logic [ACC_W:0]    acc_sum;
  logic              carry;

  always_comb begin
    active  = (state_q != IDLE);
    go      = (state_q == IDLE) && start && !stop;
    tick    = active && (first_q || (cnt_q == div_act_q));
    acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
    carry   = acc_sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (go) state_d = RUN;
      RUN:      if (stop) state_d = STOPPING;
      STOPPING: if (tick && carry) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef WAVE_ROM_SEQ_AMP_EN
  always_comb prod = {8'd0, rom_dout} * {{DATA_W{1'b0}}, amp};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      ftw_q       <= '0;
      poff_q      <= '0;
      div_q       <= '0;
      div_act_q   <= '0;
      rom_ad_q    <= '0;
      rom_ce_q    <= 1'b0;
      rd_q        <= 1'b0;
      wrap_q      <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
`ifdef WAVE_ROM_SEQ_AMP_EN
      amp_v_q     <= 1'b0;
      prod_q      <= '0;
`endif
    end else begin
      if (cfg_we) begin
        ftw_q  <= cfg_ftw;
        poff_q <= cfg_poff;
        div_q  <= cfg_div;
      end
      // The divider period in use only changes at a tick so the counter never overshoots it.
      if (!active || tick) div_act_q <= div_q;

      if (go) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        first_q <= 1'b1;
      end else if (tick) begin
        acc_q    <= acc_sum[ACC_W-1:0];
        cnt_q    <= '0;
        first_q  <= 1'b0;
        rom_ad_q <= acc_q[ACC_W-1 -: ADDR_W] + poff_q;
      end else if (active) begin
        cnt_q <= cnt_q + DIV_W'(1);
      end

      rom_ce_q <= tick;
      wrap_q   <= tick && carry;
      rd_q     <= rom_ce_q;
`ifdef WAVE_ROM_SEQ_AMP_EN
      amp_v_q <= rd_q;
      if (rd_q) prod_q <= prod[DATA_W+7:8];
      dac_valid_q <= amp_v_q;
      if (amp_v_q) dac_data_q <= prod_q;
`else
      dac_valid_q <= rd_q;
      if (rd_q) dac_data_q <= rom_dout;
`endif
    end
  end

  always_comb begin
    rom_ce    = rom_ce_q;
    rom_oce   = 1'b1;
    rom_ad    = rom_ad_q;
    dac_data  = dac_data_q;
    dac_valid = dac_valid_q;
    wrap      = wrap_q;
    state_dbg = state_q;
`ifdef WAVE_ROM_SEQ_AMP_EN
    busy = active || rom_ce_q || rd_q || amp_v_q || dac_valid_q;
`else
    busy = active || rom_ce_q || rd_q || dac_valid_q;
`endif
  end

endmodule

// File: tb/tb_wave_rom_seq.sv
// Self-checking bench for wave_rom_seq: a ROM model, a tick/accumulator reference model that
// pushes expected {cycle, sample} pairs, and a scoreboard that pops them on each dac_valid.
module tb_wave_rom_seq;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef WAVE_ROM_SEQ_AMP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cfg_we = 1'b0;
  logic [ACC_W-1:0]  cfg_ftw = '0;
  logic [ADDR_W-1:0] cfg_poff = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              rom_ce;
  logic              rom_oce;
  logic [ADDR_W-1:0] rom_ad;
  logic [DATA_W-1:0] rom_dout = '0;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              wrap;
  logic              busy;
  logic [1:0]        state_dbg;
`ifdef WAVE_ROM_SEQ_AMP_EN
  logic [7:0]        amp = 8'd181;
`endif

  wave_rom_seq #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_we(cfg_we),
    .cfg_ftw(cfg_ftw), .cfg_poff(cfg_poff), .cfg_div(cfg_div),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_ad(rom_ad), .rom_dout(rom_dout),
`ifdef WAVE_ROM_SEQ_AMP_EN
    .amp(amp),
`endif
    .dac_data(dac_data), .dac_valid(dac_valid), .wrap(wrap), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ROM tables: a varied pattern, or the square table (0xFF lower half, 0x00 upper half)
  bit sq_mode = 1'b0;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (sq_mode) return (a < 11'h400) ? 8'hFF : 8'h00;
    return a[7:0] ^ {a[10:8], 5'b10101};
  endfunction

  function automatic logic [7:0] exp_sample(input logic [10:0] a);
`ifdef WAVE_ROM_SEQ_AMP_EN
    logic [15:0] p;
    p = {8'd0, rom_fn(a)} * {8'd0, amp};
    return p[15:8];
`else
    return rom_fn(a);
`endif
  endfunction

  always @(posedge clk) if (rom_ce) rom_dout <= rom_fn(rom_ad);

  // Scoreboard state
  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid = 0, n_wrap = 0, n_ce = 0;
  int last_valid_cyc = 0, last_wrap_cyc = 0;
  logic [7:0] last_exp_data = 8'h00;

  // Reference model: ticks on the first RUN cycle then every m_div+1 cycles
  bit          m_on = 1'b0;
  int          m_start = 0, m_div = 0, m_stop_from = 0;
  logic [31:0] m_acc = '0, m_ftw = '0;
  logic [10:0] m_poff = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic [39:0] e;
    logic [32:0] s;
    @(negedge clk);
    cyc++;
    if (dac_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) chk("dac_unexpected", {63'd0, dac_valid}, 64'd0);
      else begin
        e = exp_q.pop_front();
        last_exp_data = e[7:0];
        chk("dac_cycle", cyc, e[39:8]);
        chk("dac_data", dac_data, e[7:0]);
      end
    end
    if (wrap) begin
      n_wrap++;
      last_wrap_cyc = cyc;
    end
    if (rom_ce) n_ce++;
    if (m_on && cyc > m_start && ((cyc - m_start - 1) % (m_div + 1)) == 0) begin
      s = {1'b0, m_acc} + {1'b0, m_ftw};
      exp_q.push_back({32'(cyc + LAT), exp_sample(m_acc[31:21] + m_poff)});
      m_acc = s[31:0];
      if (m_stop_from != 0 && cyc >= m_stop_from && s[32]) m_on = 1'b0;
    end
  endtask

  // Driver tasks
  task automatic set_cfg(input logic [31:0] ftw, input logic [10:0] poff, input int div);
    cfg_we = 1'b1; cfg_ftw = ftw; cfg_poff = poff; cfg_div = DIV_W'(div);
    m_ftw = ftw; m_poff = poff; m_div = div;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    m_on = 1'b1; m_start = cyc; m_acc = '0; m_stop_from = 0;
    step();
    start = 1'b0;
  endtask

  task automatic req_stop();
    stop = 1'b1;
    m_stop_from = cyc + 1;
    step();
    stop = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    m_on = 1'b0;
    step();
    chk("rst_rom_ce", rom_ce, 0);
    chk("rst_rom_ad", rom_ad, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    chk("rom_oce", rom_oce, 1);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_state", state_dbg, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int s0, v0, w0, ce0;

  initial begin
    step(); step();
    apply_reset();
    step();

    // Ramp: rom_ad 0,1,2,... from S+2, first dac_valid LAT+1 cycles after start
    set_cfg(32'h0020_0000, 11'h000, 0);
    step();
    go();
    s0 = m_start;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("ramp_rom_ad", rom_ad, 11'(cyc - s0 - 2));
      chk("ramp_rom_ce", rom_ce, 1);
    end
    chk("ramp_first_valid_seen", n_valid >= 1, 1);

    // Reset mid-RUN: outputs clear, nothing in flight survives
    apply_reset();
    v0 = n_valid;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_busy", busy, 0);
    end
    chk("post_rst_no_valid", n_valid - v0, 0);

    // Divider of 3: one tick in every 4 cycles
    set_cfg(32'h0020_0000, 11'h005, 3);
    step();
    go();
    ce0 = n_ce; v0 = n_valid;
    for (int i = 0; i < 40; i++) step();
    chk("div3_rom_ce_count", n_ce - ce0, 10);
    chk("div3_valid_count", n_valid - v0, 10);
    // Faster tuning word mid-run so the graceful stop reaches a wrap quickly
    set_cfg(32'h4000_0000, 11'h005, 3);
    req_stop();
    drain();
    chk("hold_after_stop", dac_data, last_exp_data);

    // Graceful stop one cycle after start: 4 ticks, the 4th wraps
    set_cfg(32'h4000_0000, 11'h000, 0);
    step();
    v0 = n_valid; w0 = n_wrap;
    go();
    s0 = m_start;
    req_stop();
    drain();
    chk("stop_valid_count", n_valid - v0, 4);
    chk("stop_wrap_count", n_wrap - w0, 1);
    chk("stop_wrap_cycle", last_wrap_cyc, s0 + 5);
    chk("stop_last_valid", last_valid_cyc, s0 + 4 + LAT);
    chk("busy_fall_cycle", cyc, last_valid_cyc + 1);

    // Square table: poff=0 reads 0x000, then poff=0x400 reads 0x400
    sq_mode = 1'b1;
    set_cfg(32'h0020_0000, 11'h000, 0);
    go();
    s0 = m_start;
    step();
    chk("sq0_rom_ad", rom_ad, 11'h000);
    while (cyc < s0 + LAT + 1) step();
    chk("sq0_valid", dac_valid, 1);
    chk("sq0_data", dac_data, exp_sample(11'h000));
    set_cfg(32'h4000_0000, 11'h000, 0);
    req_stop();
    drain();
    set_cfg(32'h0020_0000, 11'h400, 0);
    go();
    s0 = m_start;
    step();
    chk("sq400_rom_ad", rom_ad, 11'h400);
    while (cyc < s0 + LAT + 1) step();
    chk("sq400_valid", dac_valid, 1);
    chk("sq400_data", dac_data, exp_sample(11'h400));
    apply_reset();
    sq_mode = 1'b0;

    // start and stop together in IDLE: nothing happens
    step();
    ce0 = n_ce;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_state", state_dbg, 0);
    chk("ss_busy", busy, 0);
    for (int i = 0; i < 4; i++) step();
    chk("ss_state_later", state_dbg, 0);
    chk("ss_busy_later", busy, 0);
    chk("ss_no_rom_ce", n_ce - ce0, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
